// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller poller: FSM states, button
// bit positions (also used by the paddle logic) and a small bit-insert helper.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Returns word with bit idx replaced by value.
    function automatic logic [7:0] insertBit(input logic [7:0] word,
                                             input logic [2:0] idx,
                                             input logic       value);
        logic [7:0] result;
        result      = word;
        result[idx] = value;
        return result;
    endfunction

endpackage

// File: rtl/nes_sync2.sv
// Two-flop synchronizer for one raw controller data pin.
module nes_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous pin through two flops before anyone looks at it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nes_poll_scheduler.sv
// Polls both NES controllers over a shared latch/clock pair once per
// frame_tick and publishes one 8-bit button word per player.
// Optional build macro NES_DEBOUNCE_EN: a player's buttons only update when
// two consecutive polls returned the same raw word.
module nes_poll_scheduler
    import nes_pkg::*;
#(
    parameter int HALF_PERIOD_CYCLES = 150
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       nes_data_p1,
    input  logic       nes_data_p2,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] p1_buttons,
    output logic [7:0] p2_buttons,
    output logic       buttons_valid,
    output logic       poll_overrun,
    output logic       busy
);

    localparam int TW = $clog2(2 * HALF_PERIOD_CYCLES);
    localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] LATCH_LAST = TW'(2 * HALF_PERIOD_CYCLES - 1);

    logic       syncP1;
    logic       syncP2;
    state_t     state_q;
    logic [TW-1:0] timer_q;
    logic [2:0] bitCnt_q;
    logic [7:0] shadowP1_q;
    logic [7:0] shadowP2_q;
    logic [7:0] shadowP1_d;
    logic [7:0] shadowP2_d;
    logic [7:0] p1Buttons_q;
    logic [7:0] p2Buttons_q;
    logic       latch_q;
    logic       nesClk_q;
    logic       valid_q;
    logic       busy_q;
`ifdef NES_DEBOUNCE_EN
    logic [7:0] prevP1_q;
    logic [7:0] prevP2_q;
`endif

    nes_sync2 u_sync_p1 (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (nes_data_p1),
        .q_o     (syncP1)
    );

    nes_sync2 u_sync_p2 (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (nes_data_p2),
        .q_o     (syncP2)
    );

    // Shadow words with the current slot's (inverted, active-low) sample merged in.
    always_comb begin
        shadowP1_d = insertBit(shadowP1_q, bitCnt_q, ~syncP1);
        shadowP2_d = insertBit(shadowP2_q, bitCnt_q, ~syncP2);
    end

    // Poll sequencer; the final sample and the button update share the LOW->DONE
    // edge so the new words are already visible while buttons_valid is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bitCnt_q    <= 3'd0;
            shadowP1_q  <= 8'h00;
            shadowP2_q  <= 8'h00;
            p1Buttons_q <= 8'h00;
            p2Buttons_q <= 8'h00;
            latch_q     <= 1'b0;
            nesClk_q    <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef NES_DEBOUNCE_EN
            prevP1_q    <= 8'h00;
            prevP2_q    <= 8'h00;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        state_q  <= LATCH;
                        timer_q  <= '0;
                        bitCnt_q <= 3'd0;
                        latch_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                LATCH: begin
                    if (timer_q == LATCH_LAST) begin
                        state_q <= LOW;
                        timer_q <= '0;
                        latch_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                LOW: begin
                    if (timer_q == HALF_LAST) begin
                        timer_q    <= '0;
                        shadowP1_q <= shadowP1_d;
                        shadowP2_q <= shadowP2_d;
                        if (bitCnt_q == 3'd7) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
`ifdef NES_DEBOUNCE_EN
                            if (shadowP1_d == prevP1_q) begin
                                p1Buttons_q <= shadowP1_d;
                            end
                            if (shadowP2_d == prevP2_q) begin
                                p2Buttons_q <= shadowP2_d;
                            end
                            prevP1_q <= shadowP1_d;
                            prevP2_q <= shadowP2_d;
`else
                            p1Buttons_q <= shadowP1_d;
                            p2Buttons_q <= shadowP2_d;
`endif
                        end else begin
                            state_q  <= HIGH;
                            nesClk_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                HIGH: begin
                    if (timer_q == HALF_LAST) begin
                        state_q  <= LOW;
                        timer_q  <= '0;
                        bitCnt_q <= bitCnt_q + 3'd1;
                        nesClk_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    timer_q  <= '0;
                    latch_q  <= 1'b0;
                    nesClk_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign nes_latch     = latch_q;
    assign nes_clk       = nesClk_q;
    assign p1_buttons    = p1Buttons_q;
    assign p2_buttons    = p2Buttons_q;
    assign buttons_valid = valid_q;
    assign busy          = busy_q;
    // Overrun must flag the dropped tick in its own cycle, so it is not registered.
    assign poll_overrun  = frame_tick && (state_q != IDLE);

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// Testbench for nes_poll_scheduler: instance A (T=4) runs directed table
// vectors and corner sequences, instance B (T=2) runs random polls against
// a poll-level reference model. Each instance drives an NES controller model
// that presents bit 0 while latched and shifts on every rising nes_clk.
module tb_nes_poll_scheduler;
    import nes_pkg::*;

    localparam int TA = 4;
    localparam int TB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // ---------------- instance A (T = 4) ----------------
    logic       rstA_n = 1'b0, tickA = 1'b0;
    logic       pinA1, pinA2, latchA, nclkA, validA, ovA, busyA;
    logic [7:0] btnA1, btnA2;
    logic [7:0] patA1 = 8'h00, patA2 = 8'h00;
    int         edgeA = 0;

    always @(posedge latchA) edgeA = 0;
    always @(posedge nclkA)  edgeA = edgeA + 1;
    assign pinA1 = (edgeA < 8) ? ~patA1[edgeA[2:0]] : 1'b0;
    assign pinA2 = (edgeA < 8) ? ~patA2[edgeA[2:0]] : 1'b0;

    nes_poll_scheduler #(.HALF_PERIOD_CYCLES(TA)) dutA (
        .clk           (clk),
        .reset_n       (rstA_n),
        .frame_tick    (tickA),
        .nes_data_p1   (pinA1),
        .nes_data_p2   (pinA2),
        .nes_latch     (latchA),
        .nes_clk       (nclkA),
        .p1_buttons    (btnA1),
        .p2_buttons    (btnA2),
        .buttons_valid (validA),
        .poll_overrun  (ovA),
        .busy          (busyA)
    );

    // ---------------- instance B (T = 2) ----------------
    logic       rstB_n = 1'b0, tickB = 1'b0;
    logic       pinB1, pinB2, latchB, nclkB, validB, ovB, busyB;
    logic [7:0] btnB1, btnB2;
    logic [7:0] patB1 = 8'h00, patB2 = 8'h00;
    int         edgeB = 0;

    always @(posedge latchB) edgeB = 0;
    always @(posedge nclkB)  edgeB = edgeB + 1;
    assign pinB1 = (edgeB < 8) ? ~patB1[edgeB[2:0]] : 1'b0;
    assign pinB2 = (edgeB < 8) ? ~patB2[edgeB[2:0]] : 1'b0;

    nes_poll_scheduler #(.HALF_PERIOD_CYCLES(TB)) dutB (
        .clk           (clk),
        .reset_n       (rstB_n),
        .frame_tick    (tickB),
        .nes_data_p1   (pinB1),
        .nes_data_p2   (pinB2),
        .nes_latch     (latchB),
        .nes_clk       (nclkB),
        .p1_buttons    (btnB1),
        .p2_buttons    (btnB2),
        .buttons_valid (validB),
        .poll_overrun  (ovB),
        .busy          (busyB)
    );

    // ---------------- instance selection ----------------
    logic       sel = 1'b0;
    logic       sLatch, sClk, sValid, sOv, sBusy;
    logic [7:0] sBtn1, sBtn2;
    assign sLatch = sel ? latchB : latchA;
    assign sClk   = sel ? nclkB  : nclkA;
    assign sValid = sel ? validB : validA;
    assign sOv    = sel ? ovB    : ovA;
    assign sBusy  = sel ? busyB  : busyA;
    assign sBtn1  = sel ? btnB1  : btnA1;
    assign sBtn2  = sel ? btnB2  : btnA2;

    // per-poll observations
    int validAt, validCnt, latchFirst, latchCyc, clkFirst, clkRises, clkHigh;
    int busyCyc, ovCnt, ovAt, overlap, holdBad, rstBad, endBusy;
    logic [7:0] got1, got2;

    typedef struct {
        logic [7:0] p1;
        logic [7:0] p2;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;
    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic driveTick(input logic v);
        if (sel) tickB = v;
        else     tickA = v;
    endtask

    task automatic driveReset(input logic v);
        if (sel) rstB_n = v;
        else     rstA_n = v;
    endtask

    // One poll: tick in cycle 0, optional extra tick and reset window, observe cycles 1..ncyc.
    task automatic applyStimulus(input logic [7:0] p1, input logic [7:0] p2,
                                 input int extraTick, input int rstAt, input int ncyc);
        logic prevClk;
        logic [7:0] prevB1, prevB2;
        validAt = -1; validCnt = 0; latchFirst = -1; latchCyc = 0; clkFirst = -1;
        clkRises = 0; clkHigh = 0; busyCyc = 0; ovCnt = 0; ovAt = -1; overlap = 0;
        holdBad = 0; rstBad = 0; endBusy = 0; got1 = 8'h00; got2 = 8'h00;
        prevClk = 1'b0;
        if (sel) begin patB1 = p1; patB2 = p2; end
        else     begin patA1 = p1; patA2 = p2; end
        @(negedge clk);
        driveTick(1'b1);
        prevB1 = sBtn1;
        prevB2 = sBtn2;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            driveTick(c == extraTick);
            if (rstAt >= 0) driveReset(!(c >= rstAt && c <= rstAt + 2));
            #1;
            if (sValid) begin
                validCnt++;
                if (validAt < 0) validAt = c;
                got1 = sBtn1;
                got2 = sBtn2;
            end
            if (sLatch) begin
                latchCyc++;
                if (latchFirst < 0) latchFirst = c;
            end
            if (sClk) clkHigh++;
            if (sClk && !prevClk) begin
                clkRises++;
                if (clkFirst < 0) clkFirst = c;
            end
            prevClk = sClk;
            if (sBusy) busyCyc++;
            if (sOv) begin
                ovCnt++;
                ovAt = c;
            end
            if (sLatch && sClk) overlap++;
            if ((sBtn1 !== prevB1 || sBtn2 !== prevB2) && !sValid && c != rstAt) holdBad++;
            prevB1 = sBtn1;
            prevB2 = sBtn2;
            if (c == rstAt && (sLatch || sClk || sValid || sOv || sBusy || sBtn1 != 8'h00 || sBtn2 != 8'h00))
                rstBad++;
            if (c == ncyc) endBusy = int'(sBusy);
        end
    endtask

    // Quiet window: no tick; any latch/clock/busy/valid activity is counted.
    task automatic idleWindow(input int n, output int activity);
        activity = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            driveTick(1'b0);
            #1;
            if (sBusy || sLatch || sClk || sValid) activity++;
        end
    endtask

    task automatic checkNormalPoll(input string tag, input int t, input logic [7:0] e1, input logic [7:0] e2);
        checkOutput({tag, ".validAt"},    validAt,    17 * t + 1);
        checkOutput({tag, ".validCnt"},   validCnt,   1);
        checkOutput({tag, ".latchFirst"}, latchFirst, 1);
        checkOutput({tag, ".latchCyc"},   latchCyc,   2 * t);
        checkOutput({tag, ".clkFirst"},   clkFirst,   3 * t + 1);
        checkOutput({tag, ".clkRises"},   clkRises,   7);
        checkOutput({tag, ".clkHigh"},    clkHigh,    7 * t);
        checkOutput({tag, ".busyCyc"},    busyCyc,    17 * t + 1);
        checkOutput({tag, ".overlap"},    overlap,    0);
        checkOutput({tag, ".holdBad"},    holdBad,    0);
        checkOutput({tag, ".p1"},         got1,       e1);
        checkOutput({tag, ".p2"},         got2,       e2);
    endtask

    initial begin
        int activity;
        logic [7:0] r1, r2, prev1, prev2, exp1, exp2;

        // Directed table; debounced builds only publish a word seen twice in a row.
        vecs[0] = '{8'h01, (8'h01 << BTN_RIGHT), 8'h01, 8'h80};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{8'h05, 8'h3C, 8'h05, 8'h3C};
        vecs[4] = '{8'h04, 8'h3C, 8'h04, 8'h3C};
        vecs[5] = '{8'h04, 8'h3C, 8'h04, 8'h3C};
`ifdef NES_DEBOUNCE_EN
        vecs[0].e1 = 8'h00; vecs[0].e2 = 8'h00;
        vecs[1].e1 = 8'h00; vecs[1].e2 = 8'h00;
        vecs[2].e1 = 8'h00; vecs[2].e2 = 8'h00;
        vecs[3].e1 = 8'h00; vecs[3].e2 = 8'h00;
        vecs[4].e1 = 8'h00; vecs[4].e2 = 8'h3C;
        vecs[5].e1 = 8'h04; vecs[5].e2 = 8'h3C;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst.latch", latchA, 1'b0);
        checkOutput("rst.clk",   nclkA,  1'b0);
        checkOutput("rst.valid", validA, 1'b0);
        checkOutput("rst.ovr",   ovA,    1'b0);
        checkOutput("rst.busy",  busyA,  1'b0);
        checkOutput("rst.p1",    btnA1,  8'h00);
        checkOutput("rst.p2",    btnA2,  8'h00);
        checkOutput("rst.busyB", busyB,  1'b0);
        @(negedge clk);
        rstA_n = 1'b1;
        rstB_n = 1'b1;
        @(negedge clk);

        // Table vectors, back to back at the earliest accepted tick
        sel = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].p1, vecs[i].p2, -1, -1, 17 * TA + 1);
            checkNormalPoll($sformatf("vec%0d", i), TA, vecs[i].e1, vecs[i].e2);
            checkOutput($sformatf("vec%0d.ovrCnt", i), ovCnt, 0);
        end

        // Tick mid-poll is dropped and flagged in its own cycle
        applyStimulus(8'h04, 8'h3C, 30, -1, 17 * TA + 1);
        checkOutput("ovr30.ovrCnt",   ovCnt,    1);
        checkOutput("ovr30.ovrAt",    ovAt,     30);
        checkOutput("ovr30.validCnt", validCnt, 1);
        checkOutput("ovr30.validAt",  validAt,  69);
        checkOutput("ovr30.p1",       got1,     8'h04);

        // Tick at 70 accepted; tick during DONE is an overrun and does not queue
        applyStimulus(8'h04, 8'h3C, 17 * TA + 1, -1, 17 * TA + 1);
        checkNormalPoll("tick70", TA, 8'h04, 8'h3C);
        checkOutput("doneTick.ovrAt", ovAt, 69);
        idleWindow(12, activity);
        checkOutput("doneTick.noQueue", activity, 0);

        // Reset mid-poll
        applyStimulus(8'h5A, 8'hA5, -1, 40, 17 * TA + 1);
        checkOutput("midRst.outputsZero", rstBad,   0);
        checkOutput("midRst.validCnt",    validCnt, 0);
        checkOutput("midRst.endBusy",     endBusy,  0);
        checkOutput("midRst.p1",          btnA1,    8'h00);
        checkOutput("midRst.p2",          btnA2,    8'h00);
        applyStimulus(8'h5A, 8'hA5, -1, -1, 17 * TA + 1);
`ifdef NES_DEBOUNCE_EN
        checkNormalPoll("afterRst", TA, 8'h00, 8'h00);
`else
        checkNormalPoll("afterRst", TA, 8'h5A, 8'hA5);
`endif

        // Random polls at minimum T against the poll-level model
        sel = 1'b1;
        #1;
        prev1 = 8'h00; prev2 = 8'h00; exp1 = 8'h00; exp2 = 8'h00;
        r1 = 8'h00; r2 = 8'h00;
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(3, 0) != 0) r1 = 8'($urandom);
            if ($urandom_range(3, 0) != 0) r2 = 8'($urandom);
`ifdef NES_DEBOUNCE_EN
            if (r1 == prev1) exp1 = r1;
            if (r2 == prev2) exp2 = r2;
`else
            exp1 = r1;
            exp2 = r2;
`endif
            prev1 = r1;
            prev2 = r2;
            applyStimulus(r1, r2, -1, -1, 17 * TB + 1);
            checkNormalPoll($sformatf("rnd%0d", i), TB, exp1, exp2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
